// File: rtl/time_of_day_counter_if.sv
// -----------------------------------------------------------------------------
// time_of_day_counter_if
// Absolute-time load handshake for time_of_day_counter.
//   load_valid  requester -> counter  load request, held until load_ready
//   load_hour   requester -> counter  hour to load (binary)
//   load_min    requester -> counter  minute to load (binary)
//   load_sec    requester -> counter  second to load (binary)
//   load_ready  counter -> requester  high for the single cycle the load commits
//   load_err    counter -> requester  one-cycle pulse, a field was out of range
// -----------------------------------------------------------------------------
interface time_of_day_counter_if;
  logic       load_valid;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       load_ready;
  logic       load_err;

  modport master (
    output load_valid, load_hour, load_min, load_sec,
    input  load_ready, load_err
  );

  modport slave (
    input  load_valid, load_hour, load_min, load_sec,
    output load_ready, load_err
  );
endinterface

// File: rtl/time_of_day_counter.sv
// -----------------------------------------------------------------------------
// time_of_day_counter
// Accumulates 1 Hz inc pulses into hour/min/sec. A set mode freezes time and
// lets button pulses step minutes and hours; a validated parallel load sets an
// absolute time.
//
// Optional feature macro: TWELVE_HOUR_EN (adds hour12/pm outputs; requires
// HOURS_PER_DAY=24).
//
// Ports:
//   clk         system clock
//   reset_sync  synchronous active-high reset
//   inc         one-cycle 1 Hz tick
//   set_mode    level, 1 = time frozen and adjust buttons active
//   adj_min     one-cycle pulse, +1 minute in set mode (clears seconds)
//   adj_hour    one-cycle pulse, +1 hour in set mode
//   load        load handshake (slave side of time_of_day_counter_if)
//   hour/min/sec current time, binary
//   min_tick    one-cycle pulse when sec wraps to 0
//   day_tick    one-cycle pulse when the whole time wraps to 00:00:00
//   running     1 while counting (RUN state)
//   hour12, pm  (TWELVE_HOUR_EN only) 12-hour display hour and PM flag
// -----------------------------------------------------------------------------
module time_of_day_counter #(
  parameter int HOURS_PER_DAY = 24,
  parameter int SEC_PER_MIN   = 60
) (
  input  logic                  clk,
  input  logic                  reset_sync,
  input  logic                  inc,
  input  logic                  set_mode,
  input  logic                  adj_min,
  input  logic                  adj_hour,
  time_of_day_counter_if.slave  load,
  output logic [4:0]            hour,
  output logic [5:0]            min,
  output logic [5:0]            sec,
  output logic                  min_tick,
  output logic                  day_tick,
  output logic                  running
`ifdef TWELVE_HOUR_EN
  ,
  output logic [3:0]            hour12,
  output logic                  pm
`endif
);

  generate
    if (HOURS_PER_DAY != 12 && HOURS_PER_DAY != 24) begin : g_bad_hours
      $error("time_of_day_counter: HOURS_PER_DAY must be 12 or 24");
    end
`ifdef TWELVE_HOUR_EN
    if (HOURS_PER_DAY != 24) begin : g_bad_twelve
      $error("time_of_day_counter: TWELVE_HOUR_EN needs HOURS_PER_DAY=24");
    end
`endif
  endgenerate

  localparam logic [4:0] HOUR_MAX = 5'(HOURS_PER_DAY - 1);
  localparam logic [5:0] SEC_MAX  = 6'(SEC_PER_MIN - 1);
  localparam logic [4:0] HOUR_LIM = 5'(HOURS_PER_DAY);
  localparam logic [5:0] SEC_LIM  = 6'(SEC_PER_MIN);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SET  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t     state_reg;
  logic [4:0] hour_reg;
  logic [5:0] min_reg;
  logic [5:0] sec_reg;
  logic       load_ready_reg;
  logic       load_err_reg;
  logic       min_tick_reg;
  logic       day_tick_reg;
  logic       running_reg;

  // Increment-with-wrap candidates for each field, shared by RUN and SET.
  logic       sec_wrap, min_wrap, hour_wrap;
  logic [5:0] sec_inc_next, min_inc_next;
  logic [4:0] hour_inc_next;
  logic       load_fields_ok;

  assign sec_wrap      = (sec_reg == SEC_MAX);
  assign min_wrap      = (min_reg == SEC_MAX);
  assign hour_wrap     = (hour_reg == HOUR_MAX);
  assign sec_inc_next  = sec_wrap  ? 6'd0 : sec_reg + 6'd1;
  assign min_inc_next  = min_wrap  ? 6'd0 : min_reg + 6'd1;
  assign hour_inc_next = hour_wrap ? 5'd0 : hour_reg + 5'd1;

  assign load_fields_ok = (load.load_hour < HOUR_LIM) &&
                          (load.load_min  < SEC_LIM)  &&
                          (load.load_sec  < SEC_LIM);

`ifdef TWELVE_HOUR_EN
  logic [3:0] hour12_reg;
  logic       pm_reg;

  function automatic logic [3:0] hour12_of(input logic [4:0] h);
    if (h == 5'd0)
      return 4'd12;
    else if (h > 5'd12)
      return 4'(h - 5'd12);
    else
      return 4'(h);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state_reg      <= ST_RUN;
      hour_reg       <= '0;
      min_reg        <= '0;
      sec_reg        <= '0;
      load_ready_reg <= 1'b0;
      load_err_reg   <= 1'b0;
      min_tick_reg   <= 1'b0;
      day_tick_reg   <= 1'b0;
      running_reg    <= 1'b1;
`ifdef TWELVE_HOUR_EN
      hour12_reg     <= 4'd12;
      pm_reg         <= 1'b0;
`endif
    end else begin
      load_ready_reg <= 1'b0;
      load_err_reg   <= 1'b0;
      min_tick_reg   <= 1'b0;
      day_tick_reg   <= 1'b0;

      case (state_reg)
        ST_LOAD: begin
          // Single commit cycle: load_valid, inc and adjust pulses are all
          // ignored here; the requester drops load_valid on seeing load_ready.
          if (set_mode) begin
            state_reg   <= ST_SET;
            running_reg <= 1'b0;
          end else begin
            state_reg   <= ST_RUN;
            running_reg <= 1'b1;
          end
        end

        ST_RUN, ST_SET: begin
          if (load.load_valid && load_fields_ok) begin
            // A valid load beats the mode transition and any tick/adjust.
            hour_reg       <= load.load_hour;
            min_reg        <= load.load_min;
            sec_reg        <= load.load_sec;
            state_reg      <= ST_LOAD;
            running_reg    <= 1'b0;
            load_ready_reg <= 1'b1;
`ifdef TWELVE_HOUR_EN
            hour12_reg     <= hour12_of(load.load_hour);
            pm_reg         <= (load.load_hour >= 5'd12);
`endif
          end else if (load.load_valid) begin
            // Rejected request freezes both time and state for this cycle.
            load_err_reg <= 1'b1;
          end else if (state_reg == ST_RUN) begin
            // The tick is still counted in the cycle set_mode rises.
            if (inc) begin
              sec_reg <= sec_inc_next;
              if (sec_wrap) begin
                min_tick_reg <= 1'b1;
                min_reg      <= min_inc_next;
                if (min_wrap) begin
                  hour_reg <= hour_inc_next;
`ifdef TWELVE_HOUR_EN
                  hour12_reg <= hour12_of(hour_inc_next);
                  pm_reg     <= (hour_inc_next >= 5'd12);
`endif
                  if (hour_wrap)
                    day_tick_reg <= 1'b1;
                end
              end
            end
            if (set_mode) begin
              state_reg   <= ST_SET;
              running_reg <= 1'b0;
            end
          end else begin
            // SET: inc is dropped; adjusts never carry into the next field.
            if (adj_min) begin
              min_reg <= min_inc_next;
              sec_reg <= 6'd0;
            end
            if (adj_hour) begin
              hour_reg <= hour_inc_next;
`ifdef TWELVE_HOUR_EN
              hour12_reg <= hour12_of(hour_inc_next);
              pm_reg     <= (hour_inc_next >= 5'd12);
`endif
            end
            if (!set_mode) begin
              state_reg   <= ST_RUN;
              running_reg <= 1'b1;
            end
          end
        end

        default: begin
          state_reg   <= ST_RUN;
          running_reg <= 1'b1;
        end
      endcase
    end
  end

  assign hour            = hour_reg;
  assign min             = min_reg;
  assign sec             = sec_reg;
  assign min_tick        = min_tick_reg;
  assign day_tick        = day_tick_reg;
  assign running         = running_reg;
  assign load.load_ready = load_ready_reg;
  assign load.load_err   = load_err_reg;
`ifdef TWELVE_HOUR_EN
  assign hour12          = hour12_reg;
  assign pm              = pm_reg;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
module tb_time_of_day_counter;
  localparam int HPD = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_sync, inc, set_mode, adj_min, adj_hour;
  logic [4:0] hour;
  logic [5:0] min, sec;
  logic       min_tick, day_tick, running;
`ifdef TWELVE_HOUR_EN
  logic [3:0] hour12;
  logic       pm;
`endif

  time_of_day_counter_if load_if ();

  time_of_day_counter #(.HOURS_PER_DAY(HPD), .SEC_PER_MIN(60)) dut (
    .clk        (clk),
    .reset_sync (reset_sync),
    .inc        (inc),
    .set_mode   (set_mode),
    .adj_min    (adj_min),
    .adj_hour   (adj_hour),
    .load       (load_if.slave),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .min_tick   (min_tick),
    .day_tick   (day_tick),
    .running    (running)
`ifdef TWELVE_HOUR_EN
    ,
    .hour12     (hour12),
    .pm         (pm)
`endif
  );

  typedef struct {
    int hour, min, sec;
    bit ready, err, mt, dt, run;
`ifdef TWELVE_HOUR_EN
    int h12;
    bit pm;
`endif
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: time kept as seconds since midnight, mode 0=run 1=set 2=load.
  int m_t    = 0;
  int m_mode = 0;

  function automatic void chk(string name, logic [31:0] act, int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endfunction

  task automatic step(input bit r, input bit i, input bit sm, input bit am,
                      input bit ah, input bit lv,
                      input int lh = 0, input int lm = 0, input int ls = 0);
    exp_t e;
    int h, mn, s;
    reset_sync         = r;
    inc                = i;
    set_mode           = sm;
    adj_min            = am;
    adj_hour           = ah;
    load_if.load_valid = lv;
    load_if.load_hour  = 5'(lh);
    load_if.load_min   = 6'(lm);
    load_if.load_sec   = 6'(ls);

    e = '{default: 0};
    if (r) begin
      m_t = 0;
      m_mode = 0;
    end else if (m_mode == 2) begin
      m_mode = sm ? 1 : 0;
    end else if (lv && lh < HPD && lm < 60 && ls < 60) begin
      m_t = lh * 3600 + lm * 60 + ls;
      m_mode = 2;
      e.ready = 1;
    end else if (lv) begin
      e.err = 1;
    end else if (m_mode == 0) begin
      if (i) begin
        m_t = (m_t + 1) % (HPD * 3600);
        e.mt = (m_t % 60 == 0);
        e.dt = (m_t == 0);
      end
      if (sm) m_mode = 1;
    end else begin
      h  = m_t / 3600;
      mn = (m_t / 60) % 60;
      s  = m_t % 60;
      if (am) begin
        mn = (mn + 1) % 60;
        s = 0;
      end
      if (ah) h = (h + 1) % HPD;
      m_t = h * 3600 + mn * 60 + s;
      if (!sm) m_mode = 0;
    end
    e.hour = m_t / 3600;
    e.min  = (m_t / 60) % 60;
    e.sec  = m_t % 60;
    e.run  = (m_mode == 0);
`ifdef TWELVE_HOUR_EN
    e.pm  = (e.hour >= 12);
    e.h12 = (e.hour % 12 == 0) ? 12 : e.hour % 12;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit sm = 0);
    step(0, 0, sm, 0, 0, 0);
  endtask

  // Monitor: the DUT presents a full output word every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hour",       32'(hour),             e.hour);
        chk("min",        32'(min),              e.min);
        chk("sec",        32'(sec),              e.sec);
        chk("load_ready", 32'(load_if.load_ready), int'(e.ready));
        chk("load_err",   32'(load_if.load_err), int'(e.err));
        chk("min_tick",   32'(min_tick),         int'(e.mt));
        chk("day_tick",   32'(day_tick),         int'(e.dt));
        chk("running",    32'(running),          int'(e.run));
`ifdef TWELVE_HOUR_EN
        chk("hour12",     32'(hour12),           e.h12);
        chk("pm",         32'(pm),               int'(e.pm));
`endif
        if (load_if.load_ready || load_if.load_err || min_tick || day_tick)
          $display("txn t=%0t time=%0d:%0d:%0d ready=%0b err=%0b min_tick=%0b day_tick=%0b",
                   $time, hour, min, sec, load_if.load_ready, load_if.load_err,
                   min_tick, day_tick);
      end
    end
  end

  initial begin
    bit sm_lvl;
    int lh, lm, ls;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // 61 ticks from reset: 00:01:01 with one min_tick on the 60th.
    repeat (61) step(0, 1, 0, 0, 0, 0);
    idle();

    // Load 23:59:58 (held through the LOAD cycle), then two ticks to midnight.
    step(0, 0, 0, 0, 0, 1, 23, 59, 58);
    step(0, 0, 0, 0, 0, 1, 23, 59, 58);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle();

    // Set mode from 10:20:30: ticks dropped, adjusts applied -> 12:23:00.
    step(0, 0, 0, 0, 0, 1, 10, 20, 30);
    idle(1);
    repeat (5) step(0, 1, 1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 1, 0, 0);
    repeat (2) step(0, 0, 1, 0, 1, 0);
    idle(0);
    step(0, 1, 0, 0, 0, 0);
    idle();

    // Out-of-range minute held three cycles.
    repeat (3) step(0, 1, 0, 0, 0, 1, 10, 60, 0);
    idle();

    // Load with a simultaneous tick, then reset during the LOAD cycle.
    step(0, 1, 0, 0, 0, 1, 5, 6, 7);
    step(1, 0, 0, 0, 0, 1, 5, 6, 7);
    idle();

    // 12-hour corner loads.
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);  idle();
    step(0, 0, 0, 0, 0, 1, 13, 0, 0); idle();
    step(0, 0, 0, 0, 0, 1, 12, 0, 0); idle();
    step(0, 0, 0, 0, 0, 1, 11, 59, 59); step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);

    // Randomized traffic.
    sm_lvl = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) sm_lvl = ~sm_lvl;
      if ($urandom_range(0, 1) == 1) begin
        lh = $urandom_range(0, 23); lm = $urandom_range(0, 59); ls = $urandom_range(0, 59);
        if ($urandom_range(0, 3) == 0) begin lm = 59; ls = $urandom_range(50, 59); end
      end else begin
        lh = $urandom_range(0, 31); lm = $urandom_range(0, 63); ls = $urandom_range(0, 63);
      end
      step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, sm_lvl,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, lh, lm, ls);
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
